// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// One slot; held operands are refreshed from the bypass network while stalled.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic        alu_src,
  input  logic [2:0]  alu_control,
  input  logic        mem_read,
  input  logic        reg_write,
  input  logic        flush,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [31:0] mem_result,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic [31:0] wb_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] store_data,
  output logic [2:0]  alu_control_o,
  output logic [4:0]  rd_o,
  output logic        mem_read_o,
  output logic        reg_write_o,
  output logic        load_use_stall
);

  typedef struct packed {
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        alu_src;
    logic [2:0]  alu_ctl;
    logic        mem_read;
    logic        reg_write;
  } slot_t;

  slot_t slot_q, slot_d;
  logic  valid_q, valid_d;
  logic  advance, hazard;

  function automatic logic [31:0] fwd(
    input logic [4:0]  a,
    input logic [31:0] d,
    input logic [4:0]  m_rd,
    input logic        m_we,
    input logic [31:0] m_res,
    input logic [4:0]  w_rd,
    input logic        w_we,
    input logic [31:0] w_res
  );
    logic [31:0] r;
    r = d;
    // MEM is younger than WB, so it wins; x0 is hardwired.
    if (a != 5'd0 && m_we && m_rd == a)
      r = m_res;
    else if (a != 5'd0 && w_we && w_rd == a)
      r = w_res;
    return r;
  endfunction

  assign op_a = fwd(slot_q.rs1_addr, slot_q.rs1_data,
                    mem_rd, mem_reg_write, mem_result,
                    wb_rd, wb_reg_write, wb_result);
  assign store_data = fwd(slot_q.rs2_addr, slot_q.rs2_data,
                          mem_rd, mem_reg_write, mem_result,
                          wb_rd, wb_reg_write, wb_result);
  assign op_b = slot_q.alu_src ? slot_q.imm : store_data;

  assign advance = !valid_q || out_ready;
  assign hazard  = valid_q && slot_q.mem_read
                && slot_q.rd != 5'd0 && in_valid
                && (rs1_addr == slot_q.rd
                 || rs2_addr == slot_q.rd);

  assign load_use_stall = hazard;
  assign in_ready       = advance && !hazard && !flush;

  assign out_valid      = valid_q;
  assign alu_control_o  = slot_q.alu_ctl;
  assign rd_o           = slot_q.rd;
  assign mem_read_o     = slot_q.mem_read;
  assign reg_write_o    = slot_q.reg_write;

  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    if (flush || (advance && hazard)) begin
      valid_d          = 1'b0;
      slot_d.mem_read  = 1'b0;
      slot_d.reg_write = 1'b0;
    end else if (advance) begin
      valid_d          = in_valid;
      slot_d.rs1_addr  = rs1_addr;
      slot_d.rs2_addr  = rs2_addr;
      slot_d.rd        = rd_addr;
      slot_d.rs1_data  = rs1_data;
      slot_d.rs2_data  = rs2_data;
      slot_d.imm       = imm;
      slot_d.alu_src   = alu_src;
      slot_d.alu_ctl   = alu_control;
      slot_d.mem_read  = in_valid && mem_read;
      slot_d.reg_write = in_valid && reg_write;
    end else begin
      // Stalled: capture bypassed values before their writers retire.
      slot_d.rs1_data = op_a;
      slot_d.rs2_data = store_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 SHALL have in_valid  input  1  decode slot valid; in_ready  output  1  stage accepts decode slot this cycle.
REQ-003 SHALL have rs1_data, rs2_data, imm  input  32 each  register-file read data and sign-extended immediate.
REQ-004 SHALL have rs1_addr, rs2_addr, rd_addr  input  5 each  source and destination register indices.
REQ-005 SHALL have alu_src  input  1  (1 = operand B from imm); alu_control  input  3  ALU op (000 add, 001 sub, 010 and, 011 or, 101 slt); mem_read, reg_write  input  1 each.
REQ-006 SHALL have flush  input  1  kill the held slot and refuse input this cycle.
REQ-007 SHALL have mem_rd  input  5, mem_reg_write  input  1, mem_result  input  32: EX/MEM forwarding source.
REQ-008 SHALL have wb_rd  input  5, wb_reg_write  input  1, wb_result  input  32: MEM/WB forwarding source.
REQ-009 SHALL have out_valid  output  1; out_ready  input  1  ALU/EX consumer accepts slot.
REQ-010 SHALL have op_a, op_b, store_data  output  32 each; alu_control_o  output  3; rd_o  output  5; mem_read_o, reg_write_o  output  1 each; load_use_stall  output  1.

Function
REQ-011 SHALL hold one slot; advance = !out_valid || out_ready.
REQ-012 SHALL define hazard = out_valid && mem_read_o && rd_o != 0 && in_valid && (rs1_addr == rd_o || rs2_addr == rd_o); load_use_stall = hazard.
REQ-013 SHALL drive in_ready = advance && !hazard && !flush, combinationally.
REQ-014 On a clock edge with flush = 1 SHALL clear out_valid, reg_write_o, mem_read_o, regardless of out_ready.
REQ-015 Else on advance with hazard SHALL load a bubble: out_valid = 0, reg_write_o = 0, mem_read_o = 0; decode slot is not consumed.
REQ-016 Else on advance SHALL capture all decode inputs and set out_valid = in_valid; when in_valid = 0, reg_write_o and mem_read_o SHALL load 0.
REQ-017 Forwarding fwd(addr, data): if addr != 0 && mem_reg_write && mem_rd == addr -> mem_result; else if addr != 0 && wb_reg_write && wb_rd == addr -> wb_result; else data (MEM priority over WB; x0 never forwarded).
REQ-018 op_a SHALL equal fwd(held rs1_addr, held rs1_data), combinationally from held state.
REQ-019 store_data SHALL equal fwd(held rs2_addr, held rs2_data); op_b SHALL equal held imm when held alu_src = 1, else store_data.
REQ-020 While out_valid && !out_ready && !flush, held rs1_data/rs2_data SHALL be rewritten each edge with the forwarded values, so a writer retiring during the hold is not lost.
REQ-021 alu_control_o, rd_o SHALL pass held values unchanged; values outside the listed op codes SHALL pass through unmodified.
REQ-022 Latency SHALL be exactly one cycle from in_valid && in_ready to out_valid.
REQ-023 Outputs while out_valid = 0 SHALL be don't-care except reg_write_o = mem_read_o = 0.

Reset
REQ-024 rst_n low SHALL immediately clear every register: out_valid 0, all data/address fields 0, alu_control_o 000, alu_src 0, reg_write_o 0, mem_read_o 0.
REQ-025 Reset asserted mid-hold SHALL discard the held slot; first accept SHALL be possible on the first edge after rst_n rises.

Verification
REQ-026 Back-to-back: in_valid = 1, out_ready = 1, add x3 = x1 + x2 with rs1_data = 5, rs2_data = 7 -> next cycle out_valid = 1, op_a = 5, op_b = 7, alu_control_o = 000.
REQ-027 Forward priority: held rs1_addr = 4, mem_rd = wb_rd = 4 both writing, mem_result = 0x11, wb_result = 0x22 -> op_a = 0x11; with rs1_addr = 0 -> op_a = held rs1_data.
REQ-028 Load-use: held lw rd_o = 6, incoming rs2_addr = 6 -> load_use_stall = 1, in_ready = 0; next cycle out_valid = 0, then slot accepted with in_ready = 1.
REQ-029 Hold refresh: out_ready = 0 three cycles, wb writes rs1 = 0x99 in cycle 2 only -> op_a = 0x99 when out_ready rises.
REQ-030 Flush with out_ready = 0 and in_valid = 1 -> in_ready = 0; next cycle out_valid = 0, reg_write_o = 0; rst_n pulse mid-hold -> all outputs zero immediately.
